credit_manager: RTL and testbench
=================================

# credit_manager

Coin-side counterpart of the vending purchase logic. Accepts inserted coins, accumulates and publishes the 8-bit `credit` consumed by the purchase logic, and deducts the product price when a vend pulse (`apple`/`banana`/`carrot`/`date`) returns. It also refunds credit as a greedy quarter/dime/nickel coin stream over a valid/ack handshake to the change dispenser.

## Interface
- `MAX_CREDIT`, 200: credit ceiling in cents; must be ≤ 255 and a multiple of 5.
- `PRICE_APPLE`, 75: cents deducted on `apple`.
- `PRICE_BANANA`, 20: cents deducted on `banana`.
- `PRICE_CARROT`, 30: cents deducted on `carrot`.
- `PRICE_DATE`, 40: cents deducted on `date`.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low.
- `coin_valid` input 1: one coin offered this cycle.
- `coin_type` input 2: 0 = nickel (5), 1 = dime (10), 2 = quarter (25), 3 = dollar (100).
- `cancel` input 1: request refund of all credit.
- `apple`, `banana`, `carrot`, `date` input 1 each: single-cycle vend pulses from the purchase logic.
- `error` input 1: purchase rejected; counted only.
- `credit` output 8: current credit in cents, registered.
- `coin_accept` output 1: registered pulse, coin added.
- `coin_reject` output 1: registered pulse, coin returned to the customer.
- `change_valid` output 1: a change coin is offered.
- `change_coin` output 2: 0 = nickel, 1 = dime, 2 = quarter; stable while `change_valid` is high.
- `change_ack` input 1: dispenser took the offered coin.
- `error_count` output 4: saturating count of `error` pulses.

## Operation
- States: IDLE and REFUND.
- **IDLE:**
  - Priority is vend > cancel > coin.
  - Vend pulse: `credit` ← `credit` − price, clamped at 0. If `REMAINDER_REFUND_EN` is defined and the result is nonzero, go to REFUND.
  - More than one vend pulse in the same cycle: use the highest-priced product's price only.
  - `cancel` with `credit` > 0: go to REFUND. `cancel` with `credit` = 0: no effect.
  - `coin_valid`, no vend, no cancel:
    - If `credit` + value ≤ `MAX_CREDIT`: add the value and pulse `coin_accept`.
    - Otherwise: `credit` unchanged and pulse `coin_reject`.
    - The sum is computed at 9 bits, so there is no wrap-around.
  - `coin_valid` coinciding with a vend or with `cancel`: pulse `coin_reject`.
- **REFUND:**
  - `change_valid` = 1.
  - `change_coin` = quarter if `credit` ≥ 25, else dime if ≥ 10, else nickel.
  - On a cycle with `change_ack` = 1: subtract that coin's value from `credit`. Return to IDLE when the result is 0.
  - Every `coin_valid` in REFUND pulses `coin_reject`.
  - Vend pulses and `cancel` in REFUND are ignored.
- `error` increments `error_count` in any state, saturating at 15. It does not touch `credit`.
- `credit` is always a multiple of 5, so greedy change always terminates exactly.

## Timing
- Reset values: `credit` = 0, `coin_accept` = 0, `coin_reject` = 0, `change_valid` = 0, `change_coin` = 0, `error_count` = 0, state = IDLE.
  - Reset mid-REFUND abandons the remaining credit.
- Coin latency: `coin_valid` at edge N → `credit`, `coin_accept`/`coin_reject` updated after edge N; accept/reject pulses are exactly one cycle.
- Vend latency: pulse sampled at edge N → deducted `credit` visible after edge N. `change_valid` rises after edge N when entering REFUND.
- Handshake:
  - A coin transfers on every edge where `change_valid` and `change_ack` are both 1.
  - The next coin and the decremented `credit` appear after that edge, so back-to-back ack gives one coin per cycle.
  - `change_ack` while `change_valid` = 0 is ignored.
  - `change_valid` falls after the edge on which the final coin is acked.

## Configuration
- `REMAINDER_REFUND_EN` defined: every vend that leaves nonzero credit automatically refunds the remainder via REFUND.
- `REMAINDER_REFUND_EN` undefined: the remainder stays as `credit` for further purchases; REFUND is entered only on `cancel`.

## Test plan
- Reset release, then coins quarter, quarter, quarter, dime → `credit` 25, 50, 75, 85; four `coin_accept` pulses.
- `credit` 195 + nickel → 200 accepted. Then dime → `coin_reject`, `credit` stays 200.
- `credit` 85, `apple` pulse, macro defined, `change_ack` held high → `credit` 10; coin stream: dime; back to IDLE with `credit` 0. Same with macro undefined → `credit` 10, stays IDLE.
- `credit` 45, `cancel`, ack on every other cycle → coins quarter, dime, dime; `credit` 20, 10, 0; `change_coin` stable while unacked. A coin inserted mid-refund → `coin_reject`.
- Same-cycle `banana` + `coin_valid` (quarter) at `credit` 30 → `credit` 10, `coin_reject`. Then 17 `error` pulses → `error_count` = 15.
- Assert `reset` low while in REFUND with `credit` 35 → all outputs zero immediately, with no clock edge required.

Source files
------------

// File: rtl/credit_manager.sv
// Coin credit accumulator with vend deduction and greedy quarter/dime/nickel refund; REMAINDER_REFUND_EN auto-refunds leftover credit after a vend.
// Latency: all outputs registered or decoded from registered state, one edge per update; refund stream advances one coin per acked edge and holds while change_ack is low.
module credit_manager #(
  parameter int unsigned MAX_CREDIT   = 200,
  parameter int unsigned PRICE_APPLE  = 75,
  parameter int unsigned PRICE_BANANA = 20,
  parameter int unsigned PRICE_CARROT = 30,
  parameter int unsigned PRICE_DATE   = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       cancel,
  input  logic       apple,
  input  logic       banana,
  input  logic       carrot,
  input  logic       date,
  input  logic       error,
  output logic [7:0] credit,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       change_valid,
  output logic [1:0] change_coin,
  input  logic       change_ack,
  output logic [3:0] error_count
);

  localparam logic [7:0] P_APPLE  = 8'(PRICE_APPLE);
  localparam logic [7:0] P_BANANA = 8'(PRICE_BANANA);
  localparam logic [7:0] P_CARROT = 8'(PRICE_CARROT);
  localparam logic [7:0] P_DATE   = 8'(PRICE_DATE);
  localparam logic [8:0] MAX_C    = 9'(MAX_CREDIT);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFUND = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       accept_q, accept_d;
  logic       reject_q, reject_d;
  logic [3:0] err_cnt_q, err_cnt_d;

  logic       vend_any;
  logic       vend_refund;
  logic [7:0] vend_price;
  logic [7:0] vend_result;
  logic [7:0] coin_value;
  logic [8:0] coin_sum;
  logic [1:0] chg_code;
  logic [7:0] chg_value;

  assign vend_any = apple | banana | carrot | date;

  // Simultaneous vend pulses charge only the most expensive product.
  always_comb begin
    vend_price = '0;
    if (apple  && (P_APPLE  > vend_price)) vend_price = P_APPLE;
    if (banana && (P_BANANA > vend_price)) vend_price = P_BANANA;
    if (carrot && (P_CARROT > vend_price)) vend_price = P_CARROT;
    if (date   && (P_DATE   > vend_price)) vend_price = P_DATE;
  end

  assign vend_result = (credit_q > vend_price) ? (credit_q - vend_price) : 8'd0;

`ifdef REMAINDER_REFUND_EN
  assign vend_refund = vend_any && (vend_result != 8'd0);
`else
  assign vend_refund = 1'b0;
`endif

  always_comb begin
    coin_value = 8'd5;
    case (coin_type)
      2'd0:    coin_value = 8'd5;
      2'd1:    coin_value = 8'd10;
      2'd2:    coin_value = 8'd25;
      default: coin_value = 8'd100;
    endcase
  end

  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value};

  // Greedy change selection; credit stays a multiple of 5 so this always lands on 0.
  always_comb begin
    chg_code  = 2'd0;
    chg_value = 8'd5;
    if (credit_q >= 8'd25) begin
      chg_code  = 2'd2;
      chg_value = 8'd25;
    end else if (credit_q >= 8'd10) begin
      chg_code  = 2'd1;
      chg_value = 8'd10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (vend_refund) begin
          state_d = ST_REFUND;
        end else if (!vend_any && cancel && (credit_q != 8'd0)) begin
          state_d = ST_REFUND;
        end
      end
      ST_REFUND: begin
        if ((credit_q == 8'd0) || (change_ack && (credit_q == chg_value))) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    change_valid = (state_q == ST_REFUND);
    change_coin  = (state_q == ST_REFUND) ? chg_code : 2'd0;
    credit       = credit_q;
    coin_accept  = accept_q;
    coin_reject  = reject_q;
    error_count  = err_cnt_q;
  end

  always_comb begin
    credit_d  = credit_q;
    accept_d  = 1'b0;
    reject_d  = 1'b0;
    err_cnt_d = err_cnt_q;

    if (error && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (vend_any) begin
          credit_d = vend_result;
          reject_d = coin_valid;
        end else if (cancel) begin
          reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_sum <= MAX_C) begin
            credit_d = coin_sum[7:0];
            accept_d = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_REFUND: begin
        reject_d = coin_valid;
        if (change_ack && (credit_q != 8'd0)) begin
          credit_d = credit_q - chg_value;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q  <= '0;
      accept_q  <= 1'b0;
      reject_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      credit_q  <= credit_d;
      accept_q  <= accept_d;
      reject_q  <= reject_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_credit_manager.sv
// Directed walk through the coin/vend/refund scenarios followed by a randomized run against a behavioural model.
module tb_credit_manager;

  localparam int MAXC = 200;
  localparam int PRICES [4] = '{75, 20, 30, 40};
  localparam int COINV [4] = '{5, 10, 25, 100};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       cancel = 1'b0;
  logic       apple = 1'b0, banana = 1'b0, carrot = 1'b0, date = 1'b0;
  logic       error = 1'b0;
  logic       change_ack = 1'b0;
  logic [7:0] credit;
  logic       coin_accept, coin_reject, change_valid;
  logic [1:0] change_coin;
  logic [3:0] error_count;

  int checks = 0;
  int errors = 0;

  credit_manager dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .apple(apple), .banana(banana), .carrot(carrot), .date(date),
    .error(error), .credit(credit), .coin_accept(coin_accept), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_coin(change_coin), .change_ack(change_ack),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gval(input int c);
    return (c >= 25) ? 25 : (c >= 10) ? 10 : 5;
  endfunction

  function automatic int gcode(input int c);
    return (c >= 25) ? 2 : (c >= 10) ? 1 : 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add_ok(input int t, input int exp_credit);
    coin_valid = 1'b1;
    coin_type  = 2'(t);
    cyc();
    coin_valid = 1'b0;
    chk("coin_credit", credit, exp_credit);
    chk("coin_accept", coin_accept, 1);
    chk("coin_reject", coin_reject, 0);
  endtask

  // Drains start cents through the refund stream with ack held high.
  task automatic drain(input int start, input bit need_cancel);
    int cr;
    cr = start;
    if (need_cancel) begin
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
    end
    change_ack = 1'b1;
    while (cr > 0) begin
      chk("drain_valid", change_valid, 1);
      chk("drain_coin", change_coin, gcode(cr));
      cyc();
      cr -= gval(cr);
      chk("drain_credit", credit, cr);
    end
    change_ack = 1'b0;
    chk("drain_done", change_valid, 0);
  endtask

  initial begin
    int m_cr, m_ec, price, v;
    bit m_ref, acc, rej;
    bit [3:0] vend;

    // Reset state
    repeat (2) cyc();
    chk("rst_credit", credit, 0);
    chk("rst_accept", coin_accept, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_cvalid", change_valid, 0);
    chk("rst_ccoin", change_coin, 0);
    chk("rst_errcnt", error_count, 0);
    reset = 1'b1;
    cyc();

    // Coin accumulation
    add_ok(2, 25);
    add_ok(2, 50);
    add_ok(2, 75);
    add_ok(1, 85);
    cyc();
    chk("accept_pulse_width", coin_accept, 0);

    // Ceiling
    add_ok(3, 185);
    add_ok(1, 195);
    add_ok(0, 200);
    coin_valid = 1'b1; coin_type = 2'd1;
    cyc();
    coin_valid = 1'b0;
    chk("over_reject", coin_reject, 1);
    chk("over_accept", coin_accept, 0);
    chk("over_credit", credit, 200);
    drain(200, 1'b1);

    // Apple at 85
    add_ok(2, 25);
    add_ok(2, 50);
    add_ok(2, 75);
    add_ok(1, 85);
    apple = 1'b1;
    cyc();
    apple = 1'b0;
    chk("apple_credit", credit, 10);
`ifdef REMAINDER_REFUND_EN
    chk("apple_refund", change_valid, 1);
    chk("apple_coin", change_coin, 1);
    drain(10, 1'b0);
`else
    chk("apple_idle", change_valid, 0);
    cyc();
    chk("apple_keep", credit, 10);
    chk("apple_stay_idle", change_valid, 0);
    drain(10, 1'b1);
`endif

    // Cancel at 45, ack every other cycle
    add_ok(2, 25);
    add_ok(1, 35);
    add_ok(1, 45);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    chk("cxl_valid", change_valid, 1);
    chk("cxl_coin0", change_coin, 2);
    chk("cxl_credit0", credit, 45);
    cyc();
    chk("cxl_hold_coin", change_coin, 2);
    chk("cxl_hold_credit", credit, 45);
    change_ack = 1'b1; cyc(); change_ack = 1'b0;
    chk("cxl_credit1", credit, 20);
    chk("cxl_coin1", change_coin, 1);
    coin_valid = 1'b1; coin_type = 2'd2;
    cyc();
    coin_valid = 1'b0;
    chk("cxl_mid_reject", coin_reject, 1);
    chk("cxl_mid_accept", coin_accept, 0);
    chk("cxl_mid_credit", credit, 20);
    chk("cxl_mid_coin", change_coin, 1);
    change_ack = 1'b1; cyc(); change_ack = 1'b0;
    chk("cxl_credit2", credit, 10);
    chk("cxl_coin2", change_coin, 1);
    cyc();
    change_ack = 1'b1; cyc(); change_ack = 1'b0;
    chk("cxl_credit3", credit, 0);
    chk("cxl_done", change_valid, 0);

    // Banana with a coin in the same cycle
    add_ok(2, 25);
    add_ok(0, 30);
    banana = 1'b1; coin_valid = 1'b1; coin_type = 2'd2;
    cyc();
    banana = 1'b0; coin_valid = 1'b0;
    chk("ban_credit", credit, 10);
    chk("ban_reject", coin_reject, 1);
    chk("ban_accept", coin_accept, 0);
`ifdef REMAINDER_REFUND_EN
    drain(10, 1'b0);
`else
    drain(10, 1'b1);
`endif

    // Error counter saturation
    error = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cyc();
      chk("err_count", error_count, (i > 15) ? 15 : i);
    end
    error = 1'b0;
    chk("err_credit", credit, 0);

    // Asynchronous reset in the middle of a refund
    add_ok(2, 25);
    add_ok(1, 35);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    chk("pre_rst_valid", change_valid, 1);
    chk("pre_rst_credit", credit, 35);
    reset = 1'b0;
    #2;
    chk("arst_credit", credit, 0);
    chk("arst_valid", change_valid, 0);
    chk("arst_coin", change_coin, 0);
    chk("arst_accept", coin_accept, 0);
    chk("arst_reject", coin_reject, 0);
    chk("arst_errcnt", error_count, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Randomized run against the behavioural model
    m_cr = 0; m_ec = 0; m_ref = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      coin_valid = ($urandom_range(99) < 35);
      coin_type  = 2'($urandom_range(3));
      cancel     = ($urandom_range(99) < 6);
      for (int k = 0; k < 4; k++) vend[k] = ($urandom_range(99) < 5);
      {date, carrot, banana, apple} = vend;
      error      = ($urandom_range(99) < 5);
      change_ack = ($urandom_range(99) < 50);

      acc = 1'b0; rej = 1'b0;
      if (!m_ref) begin
        if (vend != 4'd0) begin
          price = 0;
          for (int k = 0; k < 4; k++) if (vend[k] && PRICES[k] > price) price = PRICES[k];
          m_cr = (m_cr > price) ? m_cr - price : 0;
          rej = coin_valid;
`ifdef REMAINDER_REFUND_EN
          if (m_cr > 0) m_ref = 1'b1;
`endif
        end else if (cancel) begin
          if (m_cr > 0) m_ref = 1'b1;
          rej = coin_valid;
        end else if (coin_valid) begin
          v = COINV[coin_type];
          if (m_cr + v <= MAXC) begin
            m_cr += v;
            acc = 1'b1;
          end else begin
            rej = 1'b1;
          end
        end
      end else begin
        rej = coin_valid;
        if (change_ack) begin
          m_cr -= gval(m_cr);
          if (m_cr == 0) m_ref = 1'b0;
        end
      end
      if (error && m_ec < 15) m_ec++;

      cyc();
      chk("rnd_credit", credit, m_cr);
      chk("rnd_accept", coin_accept, int'(acc));
      chk("rnd_reject", coin_reject, int'(rej));
      chk("rnd_valid", change_valid, int'(m_ref));
      if (m_ref) chk("rnd_coin", change_coin, gcode(m_cr));
      chk("rnd_errcnt", error_count, m_ec);
    end
    coin_valid = 1'b0; cancel = 1'b0; error = 1'b0; change_ack = 1'b0;
    {date, carrot, banana, apple} = 4'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
